// File: rtl/bubble_sort_pkg.sv
// Shared types and helpers for the iterative odd-even transposition sorter.
//   state_t : controller states (IDLE/SORT/DONE)
//   phase_t : which neighbour pairs a pass compares (EVEN: (0,1),(2,3)..; ODD: (1,2),(3,4)..)
//   pass_cnt_w(dim) : width of a counter that can hold 0..dim
package bubble_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  localparam int unsigned CLEAN_W = 2;

  function automatic int unsigned pass_cnt_w(input int unsigned dim);
    return $clog2(dim + 1);
  endfunction

endpackage

// File: rtl/oe_pass.sv
// One odd-even transposition pass: compare-swaps every pair selected by the phase.
// Ports:
//   i_arr        : packed input array, element k at [k*WIDTH +: WIDTH]
//   i_phase      : EVEN compares (0,1),(2,3)..; ODD compares (1,2),(3,4)..
//   o_arr_c      : array after the pass (combinational)
//   o_any_swap_c : at least one pair was swapped (combinational)
module oe_pass
  import bubble_sort_pkg::*;
#(
  parameter int unsigned DIM   = 10,
  parameter int unsigned WIDTH = 8
) (
  input  logic [DIM*WIDTH-1:0] i_arr,
  input  phase_t               i_phase,
  output logic [DIM*WIDTH-1:0] o_arr_c,
  output logic                 o_any_swap_c
);

  // Pairs within one phase are disjoint, so every compare reads the unmodified input.
  // Elements without a partner in this phase fall through the default copy.
  always_comb begin
    o_arr_c      = i_arr;
    o_any_swap_c = 1'b0;
    for (int unsigned k = 0; k + 1 < DIM; k++) begin
      if (1'(k) == 1'(i_phase)) begin
        // strict compare: equal elements stay put and do not count as a swap
        if (i_arr[k*WIDTH +: WIDTH] > i_arr[(k+1)*WIDTH +: WIDTH]) begin
          o_arr_c[k*WIDTH +: WIDTH]     = i_arr[(k+1)*WIDTH +: WIDTH];
          o_arr_c[(k+1)*WIDTH +: WIDTH] = i_arr[k*WIDTH +: WIDTH];
          o_any_swap_c                  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bubble_sort_seq.sv
// Iterative sorter: one odd-even transposition pass per clock with early exit.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, prand = packed unsorted array
//   out_valid/out_ready : output handshake, pord = packed ascending array
//   pass_cnt            : passes used by the current or last sort
//   busy                : high while sorting
module bubble_sort_seq
  import bubble_sort_pkg::*;
#(
  parameter int unsigned DIM   = 10,
  parameter int unsigned WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DIM*WIDTH-1:0]            prand,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DIM*WIDTH-1:0]            pord,
  output logic [pass_cnt_w(DIM)-1:0]      pass_cnt,
  output logic                            busy
);

  localparam int unsigned PCW = pass_cnt_w(DIM);
  localparam int unsigned DW  = DIM * WIDTH;

  state_t               r_state,    w_state_nxt;
  logic [DW-1:0]        r_data,     w_data_nxt;
  logic [PCW-1:0]       r_pass_cnt, w_pass_cnt_nxt;
  phase_t               r_phase,    w_phase_nxt;
  logic [CLEAN_W-1:0]   r_clean,    w_clean_nxt;
  logic                 r_in_ready, r_out_valid, r_busy;
  logic [DW-1:0]        w_pass_arr;
  logic                 w_any_swap;

  oe_pass #(
    .DIM   (DIM),
    .WIDTH (WIDTH)
  ) u_pass (
    .i_arr        (r_data),
    .i_phase      (r_phase),
    .o_arr_c      (w_pass_arr),
    .o_any_swap_c (w_any_swap)
  );

  // State and datapath registers; handshake flags are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_pass_cnt  <= '0;
      r_phase     <= EVEN;
      r_clean     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_pass_cnt  <= w_pass_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_clean     <= w_clean_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt == SORT);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt    = r_state;
    w_data_nxt     = r_data;
    w_pass_cnt_nxt = r_pass_cnt;
    w_phase_nxt    = r_phase;
    w_clean_nxt    = r_clean;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_data_nxt     = prand;
          w_pass_cnt_nxt = '0;
          w_phase_nxt    = EVEN;
          w_clean_nxt    = '0;
          w_state_nxt    = SORT;
        end
      end
      SORT: begin
        w_data_nxt     = w_pass_arr;
        w_pass_cnt_nxt = r_pass_cnt + PCW'(1);
        w_phase_nxt    = (r_phase == EVEN) ? ODD : EVEN;
        // consecutive swap-free passes, saturating at 2
        if (w_any_swap)
          w_clean_nxt = '0;
        else if (r_clean == CLEAN_W'(2))
          w_clean_nxt = CLEAN_W'(2);
        else
          w_clean_nxt = r_clean + CLEAN_W'(1);
        // an even and an odd pass both swap-free means sorted; DIM passes always suffice
        if ((w_clean_nxt == CLEAN_W'(2)) || (w_pass_cnt_nxt == PCW'(DIM)))
          w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign pord      = r_data;
  assign pass_cnt  = r_pass_cnt;

endmodule
